// File: rtl/rr_arb_vn_p.sv
// Round-robin arbiter over the flattened VN x VC request vector.
// Sticky registered grant; pointer advances past each accepted winner.
module rr_arb_vn_p #(
    parameter int NUM_VC = 1,
    parameter int NUM_VN = 3,
    localparam int NUM_VN_X_VC = NUM_VC * NUM_VN,
    localparam int bits_VN_X_VC = (NUM_VN_X_VC > 1) ? $clog2(NUM_VN_X_VC) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_VN_X_VC-1:0]  req,
    input  logic                    ack,
    output logic [NUM_VN_X_VC-1:0]  grant,
    output logic                    grant_valid,
    output logic [bits_VN_X_VC-1:0] grant_id,
    output logic [bits_VN_X_VC-1:0] ptr
);

    localparam int N = NUM_VN_X_VC;
    localparam int W = bits_VN_X_VC;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [W-1:0]   id_q, id_d;
    logic [W-1:0]   ptr_q, ptr_d;

    logic [W-1:0]   ptr_inc;
    logic [W-1:0]   arb_ptr;
    logic [W-1:0]   win;
    logic           win_vld;
    logic [N-1:0]   win_oh;

    assign ptr_inc = (id_q == W'(N - 1)) ? '0 : id_q + 1'b1;

    // On an accepted grant, re-arbitrate from the advanced pointer.
    assign arb_ptr = (state_q == GRANT && ack) ? ptr_inc : ptr_q;

    // Scan from the highest offset down so the lowest offset wins.
    always_comb begin
        logic [W:0] sum;
        sum     = '0;
        win     = '0;
        win_vld = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            sum = {1'b0, arb_ptr} + (W+1)'(k);
            if (sum >= (W+1)'(N)) begin
                sum = sum - (W+1)'(N);
            end
            if (req[sum[W-1:0]]) begin
                win     = sum[W-1:0];
                win_vld = 1'b1;
            end
        end
    end

    assign win_oh = N'(1) << win;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = GRANT;
                    grant_d = win_oh;
                    id_d    = win;
                end
            end
            GRANT: begin
                if (ack) begin
                    ptr_d = ptr_inc;
                    if (win_vld) begin
                        grant_d = win_oh;
                        id_d    = win;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                        id_d    = '0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = (state_q == GRANT);
    assign grant_id    = id_q;
    assign ptr         = ptr_q;

endmodule

// File: tb/tb_rr_arb_vn_p.sv
// Directed and random checks of rr_arb_vn_p against a scoreboarded model.
// A second instance with six requesters covers non-power-of-2 wrap.
module tb_rr_arb_vn_p;

    localparam int N = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] req = '0;
    logic       ack = 1'b0;
    logic [2:0] grant;
    logic       gv;
    logic [1:0] gid;
    logic [1:0] ptr;

    logic [5:0] req6 = '0;
    logic       ack6 = 1'b0;
    logic [5:0] grant6;
    logic       gv6;
    logic [2:0] gid6;
    logic [2:0] ptr6;

    always #5 clk = ~clk;

    rr_arb_vn_p #(.NUM_VC(1), .NUM_VN(3)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
        .grant(grant), .grant_valid(gv), .grant_id(gid), .ptr(ptr)
    );

    rr_arb_vn_p #(.NUM_VC(2), .NUM_VN(3)) dut6 (
        .clk(clk), .rst_n(rst_n), .req(req6), .ack(ack6),
        .grant(grant6), .grant_valid(gv6), .grant_id(gid6), .ptr(ptr6)
    );

    typedef struct packed {
        logic [2:0] g;
        logic       v;
        logic [1:0] id;
        logic [1:0] p;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;
    int   mv, mid, mptr;
    int   waitc[N];
    int   maxwait = 0;

    function automatic int arb_ref(logic [2:0] r, int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mv = 0;
        mid = 0;
        mptr = 0;
    endtask

    task automatic model_step(logic [2:0] r, logic a);
        int w;
        if (mv == 0) begin
            w = arb_ref(r, mptr);
            if (w >= 0) begin
                mv = 1;
                mid = w;
            end
        end else if (a) begin
            mptr = (mid + 1) % N;
            w = arb_ref(r, mptr);
            if (w >= 0) begin
                mid = w;
            end else begin
                mv = 0;
                mid = 0;
            end
        end
    endtask

    task automatic compare();
        exp_t e;
        e = sbq.pop_front();
        chk("grant", 32'(grant), 32'(e.g));
        chk("grant_valid", 32'(gv), 32'(e.v));
        chk("grant_id", 32'(gid), 32'(e.id));
        chk("ptr", 32'(ptr), 32'(e.p));
        chk("onehot", 32'($onehot0(grant) && (gv == (grant != 0))), 32'd1);
    endtask

    task automatic step(logic [2:0] r, logic a);
        exp_t e;
        req = r;
        ack = a;
        model_step(r, a);
        e.g  = (mv != 0) ? 3'(1 << mid) : 3'b000;
        e.v  = (mv != 0);
        e.id = 2'(mid);
        e.p  = 2'(mptr);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        ack = 1'b0;
        req6 = '0;
        ack6 = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] g_exp [6];
        int         p_exp [6];
        logic [2:0] r;
        logic       a;

        do_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_valid", 32'(gv), 32'd0);
        chk("rst_id", 32'(gid), 32'd0);
        chk("rst_ptr", 32'(ptr), 32'd0);

        // asynchronous reset while holding a grant
        step(3'b010, 1'b0);
        chk("pre_rst_grant", 32'(grant), 32'd2);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", 32'(grant), 32'd0);
        chk("async_rst_valid", 32'(gv), 32'd0);
        chk("async_rst_id", 32'(gid), 32'd0);
        chk("async_rst_ptr", 32'(ptr), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(3'b111, 1'b0);
        chk("rst_then_111", 32'(grant), 32'd1);

        // fairness with all requesting and ack every cycle
        g_exp = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
        p_exp = '{1, 2, 0, 1, 2, 0};
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 1'b1);
            chk("fair_grant", 32'(grant), 32'(g_exp[i]));
            chk("fair_ptr", 32'(ptr), 32'(p_exp[i]));
            chk("fair_valid", 32'(gv), 32'd1);
        end

        // sticky grant while req toggles
        do_reset();
        step(3'b100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step((i % 2 == 0) ? 3'b011 : 3'b000, 1'b0);
            chk("hold_grant", 32'(grant), 32'd4);
            chk("hold_id", 32'(gid), 32'd2);
            chk("hold_ptr", 32'(ptr), 32'd0);
        end
        step(3'b011, 1'b1);
        chk("hold_next_grant", 32'(grant), 32'd1);
        chk("hold_next_ptr", 32'(ptr), 32'd0);

        // pointer wrap
        do_reset();
        step(3'b010, 1'b0);
        step(3'b001, 1'b1);
        chk("wrap_id", 32'(gid), 32'd0);
        chk("wrap_ptr", 32'(ptr), 32'd2);
        step(3'b000, 1'b1);
        chk("wrap_ptr_after", 32'(ptr), 32'd1);
        chk("wrap_idle", 32'(gv), 32'd0);

        // drain to idle and stray ack
        do_reset();
        step(3'b010, 1'b0);
        step(3'b000, 1'b1);
        chk("drain_valid", 32'(gv), 32'd0);
        chk("drain_grant", 32'(grant), 32'd0);
        chk("drain_ptr", 32'(ptr), 32'd2);
        step(3'b000, 1'b1);
        chk("stray_ack_ptr", 32'(ptr), 32'd2);
        step(3'b000, 1'b0);

        // six requesters: wrap from ptr 5
        do_reset();
        req6 = 6'b010000;
        @(posedge clk);
        #1;
        chk("n6_first_id", 32'(gid6), 32'd4);
        chk("n6_first_ptr", 32'(ptr6), 32'd0);
        req6 = 6'b000010;
        ack6 = 1'b1;
        @(posedge clk);
        #1;
        chk("n6_wrap_id", 32'(gid6), 32'd1);
        chk("n6_wrap_ptr", 32'(ptr6), 32'd5);
        chk("n6_wrap_grant", 32'(grant6), 32'd2);
        ack6 = 1'b0;
        req6 = '0;

        // random traffic against the model
        do_reset();
        r = 3'b000;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(3) == 0) r = 3'($urandom);
            a = 1'($urandom_range(1));
            for (int i = 0; i < N; i++) begin
                if (!r[i] || !req[i]) begin
                    waitc[i] = 0;
                end else if (gv && a) begin
                    if (int'(gid) == i) waitc[i] = 0;
                    else waitc[i]++;
                end
                if (waitc[i] > maxwait) maxwait = waitc[i];
            end
            step(r, a);
        end
        chk("starvation_bound", 32'(maxwait <= N), 32'd1);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
